unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch path (pc_reg/if_id) and the data path (mem stage).
- Gives each requester a req/ack handshake and drives stall requests into ctrl while an access is pending.
- Lets the CPU core run against a unified memory instead of separate inst/data SRAM ports.
- Sits between the core's fetch/mem interfaces and the external SRAM.

Parameters:
- LATENCY, 1: SRAM read latency in cycles from the sram_en cycle to valid sram_rdata; legal values 1 to 7.
- STARVE_MAX, 4: number of consecutive lost arbitrations after which a pending fetch overrides data priority; legal values 1 to 15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch address; stable while if_req is high.
- if_rdata  out  32  fetched instruction; valid while if_ack is high, held afterwards.
- if_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_ack.
- d_we  in  4  byte write enables; 0 means a load.
- d_addr  in  32  data address; stable while d_req is high.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid while d_ack is high, held afterwards.
- d_ack  out  1  one-cycle completion pulse for data.
- sram_en  out  1  SRAM enable.
- sram_wen  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM address; equals {3'b0, addr[28:0]}.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.
- stallreq_if  out  1  fetch-side stall request to ctrl.
- stallreq_mem  out  1  mem-side stall request to ctrl.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; starve counter = 0; grant register = data.
  - All outputs = 0, including if_rdata and d_rdata.
  - An access in flight at reset is aborted: no ack is issued and sram_en is deasserted immediately.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any request pending: select a winner, latch its addr/we/wdata into registers, go to ISSUE.
- Winner selection in IDLE:
  - Data wins by default.
  - Fetch wins if d_req = 0, or if starve counter == STARVE_MAX.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when fetch and data are both pending and data wins.
  - Clears to 0 whenever fetch is granted.
- ISSUE (exactly one cycle):
  - sram_en = 1; sram_addr, sram_wen and sram_wdata are driven from the latched registers.
  - sram_wen = latched we for data writes, 0 for fetches and loads.
  - A wait counter is loaded with LATENCY-1.
- WAIT:
  - sram_en = 0 and sram_wen = 0.
  - The counter decrements each cycle.
  - When the counter reaches 0, sram_rdata is sampled into the winner's rdata register and the state goes to DONE.
  - With LATENCY = 1, WAIT lasts one cycle.
- DONE (one cycle):
  - The winner's ack = 1.
  - For stores, d_rdata is left unchanged.
  - Next state is IDLE.
  - Requests seen in DONE are ignored; the requester drops req in the ack cycle or later.
- Timing:
  - Request first seen in IDLE at cycle T: ISSUE at T+1, ack at T+LATENCY+2.
  - Throughput is one access per LATENCY+3 cycles.
- Stall requests are combinational:
  - stallreq_if = if_req & ~if_ack.
  - stallreq_mem = d_req & ~d_ack.
- Simultaneous requests:
  - Only the winner is served.
  - The loser stays pending and is served on the next IDLE, unless a new data request arrives first and the starve counter is below STARVE_MAX.
- Request dropped before ack: the access still completes; the ack is issued and ignored.
- if_ack and d_ack are never high in the same cycle.
- The sram_addr top 3 bits are always 0.

Decomposition:
- defines.v holds:
  - state encodings ArbIdle, ArbIssue, ArbWait, ArbDone (2-bit);
  - grant encodings GrantIf / GrantData;
  - the address-mask macro.
- One sub-module, arb_pick: combinational priority pick plus the starve counter register, with clk/rst.
- The top level holds the FSM, the latency counter and the datapath registers.

Test Plan:
- Single fetch: LATENCY = 1, if_req = 1 at T, if_addr = 0xBFC00000, sram_rdata = 0x24010001 -> sram_en = 1 and sram_addr = 0x1FC00000 at T+1; if_ack = 1 with if_rdata = 0x24010001 at T+3; stallreq_if high T..T+2.
- Simultaneous requests: d_req (load, addr 0x80001000) and if_req both rise at T -> data granted first with d_ack at T+3; fetch reaches ISSUE at T+5 and if_ack at T+7.
- Store: d_we = 4'b0011, d_wdata = 0xDEADBEEF -> sram_wen = 0011 only in the ISSUE cycle; d_ack after LATENCY+2 cycles; d_rdata unchanged.
- Starvation: STARVE_MAX = 2, d_req held continuously with fresh requests and if_req high -> data wins twice, then fetch is granted on the third arbitration and the counter returns to 0.
- LATENCY = 3: single load -> ack exactly 5 cycles after the request; sram_rdata is sampled only at the end of the third WAIT cycle (differing values on earlier cycles must not be captured).
- Reset mid-access: rst asserted during WAIT -> sram_en, acks and rdata go to 0 immediately; no ack is issued after release; a request after release is served normally.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified SRAM arbiter: FSM states, grant encoding,
// the captured access record and the physical address mask.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbIssue = 2'd1,
        ArbWait  = 2'd2,
        ArbDone  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GrantIf   = 1'b0,
        GrantData = 1'b1
    } grant_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } access_t;

    // kseg0/kseg1 style virtual addresses fold onto the low 512 MB.
    localparam logic [31:0] ADDR_MASK = 32'h1FFF_FFFF;

    function automatic logic [31:0] sram_phys(input logic [31:0] addr);
        return addr & ADDR_MASK;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_arb_pick.sv
// Priority pick between fetch and data plus the fetch starvation counter.
// Latency: pick is combinational, counter updates on the arbitration edge; no backpressure.
module unified_mem_arbiter_arb_pick
    import unified_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   arb_en,
    input  logic   if_req,
    input  logic   d_req,
    output grant_t grant
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    always_comb begin
        grant = GrantData;
        if (if_req && (!d_req || starve_cnt == SMAX)) begin
            grant = GrantIf;
        end
    end

    // Counts arbitrations that fetch lost while both sides were waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (grant == GrantIf) begin
                starve_cnt <= '0;
            end else if (if_req && starve_cnt != SMAX) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and the data path.
// Latency: ack at LATENCY+2 cycles after the request is seen idle; requesters stall via stallreq_*.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    localparam logic [2:0] WAIT_INIT = 3'(LATENCY - 1);

    arb_state_t state;
    grant_t     grant_q;
    grant_t     pick_grant;
    access_t    pick_acc;
    logic       store_q;
    logic [2:0] wait_cnt;
    logic       arb_en;

    assign arb_en = (state == ArbIdle) && (if_req || d_req);

    unified_mem_arbiter_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_arb_pick (
        .clk   (clk),
        .rst   (rst),
        .arb_en(arb_en),
        .if_req(if_req),
        .d_req (d_req),
        .grant (pick_grant)
    );

    always_comb begin
        pick_acc = '{addr: d_addr, we: d_we, wdata: d_wdata};
        if (pick_grant == GrantIf) begin
            pick_acc = '{addr: if_addr, we: 4'h0, wdata: 32'h0};
        end
    end

    assign stallreq_if  = if_req & ~if_ack;
    assign stallreq_mem = d_req & ~d_ack;

    // SRAM command outputs are loaded on the IDLE->ISSUE edge, so they are
    // the latched access registers themselves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ArbIdle;
            grant_q    <= GrantData;
            store_q    <= 1'b0;
            wait_cnt   <= '0;
            sram_en    <= 1'b0;
            sram_wen   <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            sram_en  <= 1'b0;
            sram_wen <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            case (state)
                ArbIdle: begin
                    if (arb_en) begin
                        grant_q    <= pick_grant;
                        store_q    <= |pick_acc.we;
                        sram_en    <= 1'b1;
                        sram_wen   <= pick_acc.we;
                        sram_addr  <= sram_phys(pick_acc.addr);
                        sram_wdata <= pick_acc.wdata;
                        state      <= ArbIssue;
                    end
                end
                ArbIssue: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= ArbWait;
                end
                ArbWait: begin
                    if (wait_cnt == 3'd0) begin
                        if (grant_q == GrantIf) begin
                            if_rdata <= sram_rdata;
                            if_ack   <= 1'b1;
                        end else begin
                            if (!store_q) begin
                                d_rdata <= sram_rdata;
                            end
                            d_ack <= 1'b1;
                        end
                        state <= ArbDone;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ArbDone: begin
                    state <= ArbIdle;
                end
                default: begin
                    state <= ArbIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench: three arbiter instances (LATENCY/STARVE_MAX = 1/4, 3/4, 1/2) checked
// cycle by cycle against a transaction-schedule model of the arbiter.
module tb_unified_mem_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        if_req     [N];
    logic [31:0] if_addr    [N];
    logic [31:0] if_rdata   [N];
    logic        if_ack     [N];
    logic        d_req      [N];
    logic [3:0]  d_we       [N];
    logic [31:0] d_addr     [N];
    logic [31:0] d_wdata    [N];
    logic [31:0] d_rdata    [N];
    logic        d_ack      [N];
    logic        sram_en    [N];
    logic [3:0]  sram_wen   [N];
    logic [31:0] sram_addr  [N];
    logic [31:0] sram_wdata [N];
    logic [31:0] sram_rdata [N];
    logic        stallreq_if  [N];
    logic        stallreq_mem [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        unified_mem_arbiter #(
            .LATENCY   (g == 1 ? 3 : 1),
            .STARVE_MAX(g == 2 ? 2 : 4)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .if_req      (if_req[g]),
            .if_addr     (if_addr[g]),
            .if_rdata    (if_rdata[g]),
            .if_ack      (if_ack[g]),
            .d_req       (d_req[g]),
            .d_we        (d_we[g]),
            .d_addr      (d_addr[g]),
            .d_wdata     (d_wdata[g]),
            .d_rdata     (d_rdata[g]),
            .d_ack       (d_ack[g]),
            .sram_en     (sram_en[g]),
            .sram_wen    (sram_wen[g]),
            .sram_addr   (sram_addr[g]),
            .sram_wdata  (sram_wdata[g]),
            .sram_rdata  (sram_rdata[g]),
            .stallreq_if (stallreq_if[g]),
            .stallreq_mem(stallreq_mem[g])
        );
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int k      = 0;

    // Model: one outstanding access described by its schedule.
    bit          m_busy;
    bit          m_data;
    int          m_issue, m_sample, m_ack;
    int          m_starve;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    logic [3:0]  m_we;
    bit          last_if_ack, last_d_ack;
    bit          ack_log[$];

    function automatic int lat_of(input int idx);
        return (idx == 1) ? 3 : 1;
    endfunction

    function automatic int sm_of(input int idx);
        return (idx == 2) ? 2 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (dut %0d, cycle %0d): observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            if_req[i] = 1'b0; if_addr[i] = '0; d_req[i] = 1'b0; d_we[i] = '0;
            d_addr[i] = '0; d_wdata[i] = '0; sram_rdata[i] = '0;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_sram_en",  32'(sram_en[i]),  32'h0);
            chk("rst_sram_wen", 32'(sram_wen[i]), 32'h0);
            chk("rst_sram_addr", sram_addr[i],    32'h0);
            chk("rst_if_ack",   32'(if_ack[i]),   32'h0);
            chk("rst_d_ack",    32'(d_ack[i]),    32'h0);
            chk("rst_if_rdata", if_rdata[i],      32'h0);
            chk("rst_d_rdata",  d_rdata[i],       32'h0);
        end
        m_busy = 1'b0; m_starve = 0; m_if_rdata = '0; m_d_rdata = '0;
        last_if_ack = 1'b0; last_d_ack = 1'b0;
        ack_log.delete();
        tick();
        rst = 1'b0;
    endtask

    // Checks one cycle of dut k against the model, then advances a cycle.
    task automatic cycle_step();
        bit e_en, e_ia, e_da, fetch;
        #1;
        e_en = m_busy && (cyc == m_issue);
        e_ia = m_busy && (cyc == m_ack) && !m_data;
        e_da = m_busy && (cyc == m_ack) && m_data;
        chk("sram_en",  32'(sram_en[k]),  32'(e_en));
        chk("sram_wen", 32'(sram_wen[k]), 32'((e_en && m_data) ? m_we : 4'h0));
        if (e_en) chk("sram_addr", sram_addr[k], m_addr & 32'h1FFF_FFFF);
        if (e_en && m_data) chk("sram_wdata", sram_wdata[k], m_wdata);
        chk("sram_addr_top", 32'(sram_addr[k][31:29]), 32'h0);
        chk("if_ack",   32'(if_ack[k]),   32'(e_ia));
        chk("d_ack",    32'(d_ack[k]),    32'(e_da));
        chk("if_rdata", if_rdata[k],      m_if_rdata);
        chk("d_rdata",  d_rdata[k],       m_d_rdata);
        chk("stallreq_if",  32'(stallreq_if[k]),  32'(if_req[k] && !e_ia));
        chk("stallreq_mem", 32'(stallreq_mem[k]), 32'(d_req[k] && !e_da));
        if (if_ack[k]) ack_log.push_back(1'b0);
        if (d_ack[k])  ack_log.push_back(1'b1);

        if (!m_busy) begin
            if (if_req[k] || d_req[k]) begin
                fetch  = if_req[k] && (!d_req[k] || m_starve == sm_of(k));
                m_data = !fetch;
                if (fetch) begin
                    m_starve = 0;
                    m_addr = if_addr[k]; m_we = 4'h0; m_wdata = '0;
                end else begin
                    if (if_req[k] && m_starve < sm_of(k)) m_starve++;
                    m_addr = d_addr[k]; m_we = d_we[k]; m_wdata = d_wdata[k];
                end
                m_busy   = 1'b1;
                m_issue  = cyc + 1;
                m_sample = cyc + lat_of(k) + 1;
                m_ack    = cyc + lat_of(k) + 2;
            end
        end else begin
            if (cyc == m_sample) begin
                if (!m_data) m_if_rdata = sram_rdata[k];
                else if (m_we == 4'h0) m_d_rdata = sram_rdata[k];
            end
            if (cyc == m_ack) m_busy = 1'b0;
        end
        last_if_ack = e_ia;
        last_d_ack  = e_da;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int t;
        logic [31:0] keep;
        bit exp_order [6];
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        #2;
        reset_all();

        // Single fetch, LATENCY 1.
        k = 0;
        t = cyc;
        if_req[0] = 1'b1; if_addr[0] = 32'hBFC0_0000;
        repeat (5) begin
            sram_rdata[0] = (cyc == t + 2) ? 32'h2401_0001 : $urandom;
            if (cyc == t + 4) if_req[0] = 1'b0;
            if (cyc == t + 1) chk("fetch_issue_addr", sram_addr[0], 32'h1FC0_0000);
            if (cyc == t + 3) begin
                chk("fetch_ack",   32'(if_ack[0]), 32'h1);
                chk("fetch_rdata", if_rdata[0],    32'h2401_0001);
            end
            cycle_step();
        end

        // Simultaneous load and fetch: data first, fetch on the next idle.
        t = cyc;
        d_req[0] = 1'b1; d_we[0] = 4'h0; d_addr[0] = 32'h8000_1000;
        if_req[0] = 1'b1; if_addr[0] = 32'hBFC0_0010;
        repeat (9) begin
            sram_rdata[0] = $urandom;
            if (cyc == t + 4) d_req[0] = 1'b0;
            if (cyc == t + 8) if_req[0] = 1'b0;
            if (cyc == t + 1) chk("sim_data_addr", sram_addr[0], 32'h0000_1000);
            if (cyc == t + 3) chk("sim_d_ack", 32'(d_ack[0]), 32'h1);
            if (cyc == t + 5) chk("sim_if_issue_addr", sram_addr[0], 32'h1FC0_0010);
            if (cyc == t + 7) chk("sim_if_ack", 32'(if_ack[0]), 32'h1);
            cycle_step();
        end

        // Store: byte enables only in ISSUE, load data left untouched.
        keep = m_d_rdata;
        t = cyc;
        d_req[0] = 1'b1; d_we[0] = 4'b0011; d_addr[0] = 32'h8000_2004; d_wdata[0] = 32'hDEAD_BEEF;
        repeat (5) begin
            sram_rdata[0] = $urandom;
            if (cyc == t + 4) d_req[0] = 1'b0;
            if (cyc == t + 1) chk("store_wen_issue", 32'(sram_wen[0]), 32'h3);
            if (cyc == t + 2) chk("store_wen_wait",  32'(sram_wen[0]), 32'h0);
            if (cyc == t + 3) begin
                chk("store_ack",   32'(d_ack[0]), 32'h1);
                chk("store_rdata", d_rdata[0],    keep);
            end
            cycle_step();
        end

        // Request dropped before ack still completes.
        t = cyc;
        d_req[0] = 1'b1; d_we[0] = 4'h0; d_addr[0] = 32'h0000_0040;
        repeat (5) begin
            sram_rdata[0] = $urandom;
            if (cyc == t + 1) d_req[0] = 1'b0;
            if (cyc == t + 3) chk("drop_ack", 32'(d_ack[0]), 32'h1);
            cycle_step();
        end

        // Starvation with STARVE_MAX 2: data, data, fetch, then the same again.
        k = 2;
        reset_all();
        if_req[2] = 1'b1; if_addr[2] = 32'h9FC0_0100;
        d_req[2] = 1'b1; d_we[2] = 4'h0; d_addr[2] = 32'h8000_3000;
        repeat (24) begin
            sram_rdata[2] = $urandom;
            if (last_d_ack)  d_addr[2]  = d_addr[2] + 32'd4;
            if (last_if_ack) if_addr[2] = if_addr[2] + 32'd4;
            cycle_step();
        end
        if_req[2] = 1'b0; d_req[2] = 1'b0;
        cycle_step();
        chk("starve_ack_count", 32'(ack_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < ack_log.size(); i++) begin
            chk($sformatf("starve_order_%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));
        end

        // LATENCY 3: only the third WAIT cycle's read data is captured.
        k = 1;
        reset_all();
        t = cyc;
        d_req[1] = 1'b1; d_we[1] = 4'h0; d_addr[1] = 32'hA000_0080;
        repeat (7) begin
            sram_rdata[1] = (cyc == t + 4) ? 32'h1357_9BDF : $urandom;
            if (cyc == t + 6) d_req[1] = 1'b0;
            if (cyc == t + 4) chk("lat3_no_early_ack", 32'(d_ack[1]), 32'h0);
            if (cyc == t + 5) begin
                chk("lat3_ack",   32'(d_ack[1]), 32'h1);
                chk("lat3_rdata", d_rdata[1],    32'h1357_9BDF);
            end
            cycle_step();
        end

        // Reset during WAIT aborts the access; a later request works.
        t = cyc;
        if_req[1] = 1'b1; if_addr[1] = 32'hBFC0_0200;
        repeat (3) begin
            sram_rdata[1] = $urandom;
            cycle_step();
        end
        reset_all();
        repeat (8) begin
            sram_rdata[1] = $urandom;
            cycle_step();
        end
        chk("rst_no_late_ack", 32'(ack_log.size()), 32'd0);
        t = cyc;
        if_req[1] = 1'b1; if_addr[1] = 32'hBFC0_0204;
        repeat (7) begin
            sram_rdata[1] = (cyc == t + 4) ? 32'h0BAD_F00D : $urandom;
            if (cyc == t + 6) if_req[1] = 1'b0;
            if (cyc == t + 5) begin
                chk("post_rst_ack",   32'(if_ack[1]), 32'h1);
                chk("post_rst_rdata", if_rdata[1],    32'h0BAD_F00D);
            end
            cycle_step();
        end

        // Random traffic on every configuration.
        for (int inst = 0; inst < N; inst++) begin
            k = inst;
            reset_all();
            repeat (400) begin
                sram_rdata[k] = $urandom;
                if (last_if_ack) begin
                    if ($urandom_range(3) == 0) if_addr[k] = $urandom;
                    else if_req[k] = 1'b0;
                end else if (!if_req[k] && $urandom_range(2) == 0) begin
                    if_req[k] = 1'b1; if_addr[k] = $urandom;
                end
                if (last_d_ack) begin
                    if ($urandom_range(2) == 0) begin
                        d_addr[k] = $urandom; d_wdata[k] = $urandom;
                        d_we[k] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                    end else begin
                        d_req[k] = 1'b0;
                    end
                end else if (!d_req[k] && $urandom_range(2) == 0) begin
                    d_req[k] = 1'b1; d_addr[k] = $urandom; d_wdata[k] = $urandom;
                    d_we[k] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                end
                cycle_step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
